// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// holds the returned word for decode; applies execute redirects and flags misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_START,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_squash, w_squash_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_fault, w_fault_nxt;

    logic        w_redir_ok;
    logic        w_redir_bad;

    assign w_redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        // NOTE: every next-state value starts as its current value so no path leaves it unassigned (no latches).
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_squash_nxt   = r_squash;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_fault_nxt    = r_fault;

        case (r_state)
            S_START: begin
                w_state_nxt = S_REQ;
                if (w_redir_ok) w_pc_nxt = redirect_pc;
            end
            S_REQ: begin
                if (w_redir_ok) begin
                    w_pc_nxt = redirect_pc;
                    // A request accepted alongside a redirect fetches the old PC; drop its data.
                    if (imem_ready) begin
                        w_squash_nxt = 1'b1;
                        w_state_nxt  = S_WAIT;
                    end
                end else if (imem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir_ok) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_rvalid) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_squash_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_instr_nxt    = imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir_ok) begin
                    w_pc_nxt    = redirect_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end
            end
            S_FAULT: begin
                w_valid_nxt = 1'b0;
                w_fault_nxt = 1'b1;
            end
            default: w_state_nxt = S_START;
        endcase

        // Misaligned target overrides everything: freeze the PC and park in FAULT until reset.
        if (w_redir_bad && (r_state != S_FAULT)) begin
            w_state_nxt    = S_FAULT;
            w_pc_nxt       = r_pc;
            w_instr_nxt    = r_instr;
            w_instr_pc_nxt = r_instr_pc;
            w_valid_nxt    = 1'b0;
            w_fault_nxt    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_START;
            r_pc       <= RESET_PC;
            r_squash   <= 1'b0;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_fault = r_fault;

endmodule
